// File: rtl/data_mem_lsu_if.sv
// Request/response bundle between the MEM stage (master) and the data memory LSU (slave).
// Both channels use valid/ready handshakes; the response channel carries load data and fault status.
interface data_mem_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        resp_store;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err, resp_store
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err, resp_store
  );
endinterface

// File: rtl/data_mem_lsu.sv
// Byte-enabled RV32I data memory with load/store unit: alignment/range checks,
// one-deep registered response stage, and sign/zero extension of load data.
module data_mem_lsu #(
  parameter int unsigned DEPTH_LOG2 = 12,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter string       INIT_FILE  = ""
) (
  input logic           clk,
  input logic           rst_n,
  data_mem_lsu_if.slave bus
);

  localparam int unsigned IDX_MSB = DEPTH_LOG2 + 1;

  typedef enum logic {EMPTY, FULL} state_t;

  state_t state_q, state_d;

  logic [31:0] mem [2**DEPTH_LOG2];

  logic [31:0]         off;
  logic [DEPTH_LOG2-1:0] idx;
  logic [1:0]          bo;
  logic                accept;
  logic                fault;
  logic                do_write;
  logic [3:0]          be;
  logic [31:0]         wdata_lanes;

  logic        err_q;
  logic        store_q;
  logic [2:0]  funct3_q;
  logic [1:0]  bo_q;
  logic [31:0] rd_q;
  logic [31:0] lane_data;
  logic [31:0] load_data;

  assign off      = bus.req_addr - BASE_ADDR;
  assign idx      = off[IDX_MSB:2];
  assign bo       = off[1:0];
  assign accept   = bus.req_valid && bus.req_ready;
  assign do_write = rst_n && accept && bus.req_we && !fault;

  // NOTE: every signal written in an always_comb gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    fault = (off[31:IDX_MSB+1] != '0);
    case (bus.req_funct3)
      3'd0:    ;
      3'd1:    fault = fault || bo[0];
      3'd2:    fault = fault || (bo != 2'd0);
      3'd4:    fault = fault || bus.req_we;
      3'd5:    fault = fault || bus.req_we || bo[0];
      default: fault = 1'b1;
    endcase
  end

  always_comb begin
    be          = 4'b0000;
    wdata_lanes = bus.req_wdata;
    case (bus.req_funct3[1:0])
      2'd0: begin
        be          = 4'b0001 << bo;
        wdata_lanes = {4{bus.req_wdata[7:0]}};
      end
      2'd1: begin
        be          = 4'b0011 << bo;
        wdata_lanes = {2{bus.req_wdata[15:0]}};
      end
      default: be = 4'b1111;
    endcase
  end

  // NOTE: RAM contents are deliberately left out of reset; only the write enable is gated by rst_n.
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata_lanes[8*b +: 8];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      err_q    <= 1'b0;
      store_q  <= 1'b0;
      funct3_q <= 3'd0;
      bo_q     <= 2'd0;
      rd_q     <= 32'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        err_q    <= fault;
        store_q  <= bus.req_we;
        funct3_q <= bus.req_funct3;
        bo_q     <= bo;
        rd_q     <= mem[idx];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (accept) state_d = FULL;
      FULL:    if (!accept && bus.resp_ready) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    lane_data = rd_q >> {bo_q, 3'b000};
    case (funct3_q)
      3'd0:    load_data = {{24{lane_data[7]}}, lane_data[7:0]};
      3'd1:    load_data = {{16{lane_data[15]}}, lane_data[15:0]};
      3'd2:    load_data = rd_q;
      3'd4:    load_data = {24'd0, lane_data[7:0]};
      3'd5:    load_data = {16'd0, lane_data[15:0]};
      default: load_data = 32'd0;
    endcase
  end

  always_comb begin
    bus.resp_valid = (state_q == FULL);
    bus.req_ready  = !bus.resp_valid || bus.resp_ready;
    bus.resp_err   = err_q;
    bus.resp_store = store_q;
    bus.resp_rdata = (err_q || store_q) ? 32'd0 : load_data;
  end

endmodule

// File: tb/tb_data_mem_lsu.sv
// Bench for data_mem_lsu: directed scenarios on two parameterisations plus randomized
// traffic with backpressure checked against a byte-level memory model.
module tb_data_mem_lsu;

  localparam logic [31:0] A_BASE       = 32'h0000_0000;
  localparam int unsigned A_DEPTH_LOG2 = 12;

  typedef struct {
    bit          we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    bit          err;
  } vec_t;

  typedef struct {
    logic [31:0] rd;
    bit          err;
    bit          st;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  bit   sel;

  logic        t_valid, t_we, t_rready;
  logic [2:0]  t_f3;
  logic [31:0] t_addr, t_wdata;

  logic        o_req_ready, o_resp_valid, o_resp_err, o_resp_store;
  logic [31:0] o_resp_rdata;

  int tests_run = 0;
  int fails     = 0;

  logic [7:0] mm [int unsigned];

  always #5 clk = ~clk;

  data_mem_lsu_if bus_a ();
  data_mem_lsu_if bus_b ();

  assign bus_a.req_valid  = t_valid & ~sel;
  assign bus_b.req_valid  = t_valid & sel;
  assign bus_a.req_we     = t_we;
  assign bus_b.req_we     = t_we;
  assign bus_a.req_funct3 = t_f3;
  assign bus_b.req_funct3 = t_f3;
  assign bus_a.req_addr   = t_addr;
  assign bus_b.req_addr   = t_addr;
  assign bus_a.req_wdata  = t_wdata;
  assign bus_b.req_wdata  = t_wdata;
  assign bus_a.resp_ready = t_rready;
  assign bus_b.resp_ready = t_rready;

  assign o_req_ready  = sel ? bus_b.req_ready  : bus_a.req_ready;
  assign o_resp_valid = sel ? bus_b.resp_valid : bus_a.resp_valid;
  assign o_resp_rdata = sel ? bus_b.resp_rdata : bus_a.resp_rdata;
  assign o_resp_err   = sel ? bus_b.resp_err   : bus_a.resp_err;
  assign o_resp_store = sel ? bus_b.resp_store : bus_a.resp_store;

  data_mem_lsu #(.DEPTH_LOG2(A_DEPTH_LOG2), .BASE_ADDR(A_BASE), .INIT_FILE("")) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a)
  );

  data_mem_lsu #(.DEPTH_LOG2(4), .BASE_ADDR(32'h0000_1000), .INIT_FILE("")) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b)
  );

  // Reference: memory as individual bytes, access legality from size/alignment/range arithmetic.
  task automatic model_access(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wd, output logic [31:0] rd, output bit err);
    logic [31:0]     off;
    int unsigned     size;
    longint unsigned v;
    off  = addr - A_BASE;
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    err  = (off >= (32'd4 << A_DEPTH_LOG2)) || (f3 == 3'd3) || (f3 >= 3'd6) ||
           (we && f3 >= 3'd4) || ((off % size) != 0);
    rd   = 32'd0;
    if (!err) begin
      if (we) begin
        for (int b = 0; b < int'(size); b++) mm[off + b] = wd[8*b +: 8];
      end else begin
        v = 0;
        for (int b = 0; b < int'(size); b++) v = v | (longint'(mm[off + b]) << (8*b));
        if (!f3[2] && size < 4 && v[8*size-1]) v = v - (longint'(1) << (8*size));
        rd = v[31:0];
      end
    end
  endtask

  // Drives one request with resp_ready=1 and returns what the response port shows one edge after accept.
  task automatic issue(input bit we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                       output logic v, output logic [31:0] rd, output logic e, output logic st);
    int n = 0;
    @(negedge clk);
    t_valid = 1'b1; t_we = we; t_f3 = f3; t_addr = addr; t_wdata = wd; t_rready = 1'b1;
    #1;
    while (o_req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    @(negedge clk);
    t_valid = 1'b0;
    #1;
    v = o_resp_valid; rd = o_resp_rdata; e = o_resp_err; st = o_resp_store;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = bit'(s);
      #1;
      tests_run++;
      if ({o_resp_valid, o_resp_err, o_resp_store, o_resp_rdata, o_req_ready} !== {3'b000, 32'd0, 1'b1}) begin
        fails++;
        $display("FAIL reset[%0d]: valid/err/store/rdata/ready got %b%b%b %h %b want 000 00000000 1",
                 s, o_resp_valid, o_resp_err, o_resp_store, o_resp_rdata, o_req_ready);
      end
    end
    sel = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_table(input string name, input vec_t tbl [$]);
    logic v, e, st;
    logic [31:0] rd;
    foreach (tbl[i]) begin
      issue(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wd, v, rd, e, st);
      tests_run++;
      if ({v, e, st, rd} !== {1'b1, tbl[i].err, tbl[i].we, tbl[i].rd}) begin
        fails++;
        $display("FAIL %s[%0d] addr=%h f3=%0d: valid/err/store/rdata got %b%b%b %h want 1%b%b %h",
                 name, i, tbl[i].addr, tbl[i].f3, v, e, st, rd, tbl[i].err, tbl[i].we, tbl[i].rd);
      end
    end
  endtask

  task automatic test_basic();
    vec_t tbl [$];
    sel = 1'b0;
    tbl = '{
      '{1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 32'h0,        1'b0},
      '{1'b0, 3'd2, 32'h100, 32'h0,        32'hDEADBEEF, 1'b0},
      '{1'b1, 3'd0, 32'h101, 32'h000012AA, 32'h0,        1'b0},
      '{1'b0, 3'd2, 32'h100, 32'h0,        32'hDEADAAEF, 1'b0},
      '{1'b0, 3'd0, 32'h101, 32'h0,        32'hFFFFFFAA, 1'b0},
      '{1'b0, 3'd4, 32'h101, 32'h0,        32'h000000AA, 1'b0},
      '{1'b0, 3'd1, 32'h102, 32'h0,        32'hFFFFDEAD, 1'b0},
      '{1'b0, 3'd1, 32'h103, 32'h0,        32'h0,        1'b1},
      '{1'b1, 3'd2, 32'h102, 32'h0,        32'h0,        1'b1},
      '{1'b0, 3'd2, 32'h100, 32'h0,        32'hDEADAAEF, 1'b0},
      '{1'b0, 3'd3, 32'h100, 32'h0,        32'h0,        1'b1},
      '{1'b1, 3'd4, 32'h100, 32'h0,        32'h0,        1'b1},
      '{1'b1, 3'd2, 32'h104, 32'h0BADF00D, 32'h0,        1'b0},
      '{1'b1, 3'd1, 32'h106, 32'hABCD1234, 32'h0,        1'b0},
      '{1'b0, 3'd5, 32'h106, 32'h0,        32'h00001234, 1'b0},
      '{1'b0, 3'd1, 32'h104, 32'h0,        32'hFFFFF00D, 1'b0},
      '{1'b0, 3'd2, 32'h104, 32'h0,        32'h1234F00D, 1'b0}
    };
    run_table("basic", tbl);
  endtask

  task automatic test_backpressure();
    int got = 0;
    logic [31:0] want;
    sel = 1'b0;
    @(negedge clk);
    t_valid = 1'b1; t_we = 1'b0; t_f3 = 3'd2; t_addr = 32'h100; t_rready = 1'b0;
    @(negedge clk);
    t_addr = 32'h104;
    for (int k = 0; k < 3; k++) begin
      #1;
      tests_run++;
      if ({o_resp_valid, o_req_ready, o_resp_rdata} !== {1'b1, 1'b0, 32'hDEADAAEF}) begin
        fails++;
        $display("FAIL stall[%0d]: valid/ready/rdata got %b%b %h want 10 deadaaef",
                 k, o_resp_valid, o_req_ready, o_resp_rdata);
      end
      @(negedge clk);
    end
    t_rready = 1'b1;
    #1;
    tests_run++;
    if ({o_resp_valid, o_req_ready, o_resp_rdata} !== {1'b1, 1'b1, 32'hDEADAAEF}) begin
      fails++;
      $display("FAIL handoff_ready: valid/ready/rdata got %b%b %h want 11 deadaaef",
               o_resp_valid, o_req_ready, o_resp_rdata);
    end
    @(negedge clk);
    t_valid = 1'b0;
    #1;
    tests_run++;
    if ({o_resp_valid, o_resp_rdata} !== {1'b1, 32'h1234F00D}) begin
      fails++;
      $display("FAIL handoff_data: valid/rdata got %b %h want 1 1234f00d", o_resp_valid, o_resp_rdata);
    end
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk);
      t_valid = (i < 10); t_we = 1'b0; t_f3 = 3'd2; t_addr = i[0] ? 32'h104 : 32'h100;
      #1;
      if (i > 0) begin
        want = (i % 2 == 0) ? 32'h1234F00D : 32'hDEADAAEF;
        if (o_resp_valid === 1'b1) got++;
        tests_run++;
        if ({o_resp_valid, o_resp_rdata} !== {1'b1, want}) begin
          fails++;
          $display("FAIL b2b[%0d]: valid/rdata got %b %h want 1 %h", i - 1, o_resp_valid, o_resp_rdata, want);
        end
      end
    end
    t_valid = 1'b0;
    tests_run++;
    if (got != 10) begin
      fails++;
      $display("FAIL b2b_count: got %0d responses want 10", got);
    end
  endtask

  task automatic test_reset_mid();
    logic v, e, st;
    logic [31:0] rd;
    sel = 1'b0;
    @(negedge clk);
    t_valid = 1'b1; t_we = 1'b0; t_f3 = 3'd2; t_addr = 32'h100; t_rready = 1'b0;
    @(negedge clk);
    t_we = 1'b1; t_wdata = 32'hFFFFFFFF;
    #1;
    tests_run++;
    if (o_resp_valid !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset_valid: got %b want 1", o_resp_valid);
    end
    #1;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({o_resp_valid, o_req_ready} !== 2'b01) begin
      fails++;
      $display("FAIL async_reset: valid/ready got %b%b want 01", o_resp_valid, o_req_ready);
    end
    @(negedge clk);
    @(negedge clk);
    t_valid = 1'b0; t_rready = 1'b1;
    rst_n = 1'b1;
    issue(1'b0, 3'd2, 32'h100, 32'h0, v, rd, e, st);
    tests_run++;
    if ({v, e, st, rd} !== {3'b100, 32'hDEADAAEF}) begin
      fails++;
      $display("FAIL post_reset_data: valid/err/store/rdata got %b%b%b %h want 100 deadaaef", v, e, st, rd);
    end
  endtask

  task automatic test_range();
    vec_t tbl [$];
    sel = 1'b1;
    tbl = '{
      '{1'b1, 3'd2, 32'h103C, 32'hCAFEF00D, 32'h0,        1'b0},
      '{1'b0, 3'd2, 32'h103C, 32'h0,        32'hCAFEF00D, 1'b0},
      '{1'b1, 3'd2, 32'h1040, 32'h11111111, 32'h0,        1'b1},
      '{1'b0, 3'd2, 32'h1040, 32'h0,        32'h0,        1'b1},
      '{1'b0, 3'd2, 32'h0FFC, 32'h0,        32'h0,        1'b1},
      '{1'b1, 3'd2, 32'h1000, 32'h22222222, 32'h0,        1'b0},
      '{1'b0, 3'd2, 32'h1000, 32'h0,        32'h22222222, 1'b0},
      '{1'b0, 3'd0, 32'h103F, 32'h0,        32'hFFFFFFCA, 1'b0},
      '{1'b0, 3'd4, 32'h103F, 32'h0,        32'h000000CA, 1'b0}
    };
    run_table("range", tbl);
    sel = 1'b0;
  endtask

  task automatic test_random();
    exp_t q [$];
    exp_t x;
    logic v, e, st;
    logic [31:0] rd, a;
    bit merr;
    int unsigned ncyc = 600;
    sel = 1'b0;
    for (int i = 0; i < 64; i++) begin
      a = 32'h200 + 4 * i;
      x.rd = $urandom;
      model_access(1'b1, 3'd2, a, x.rd, rd, merr);
      issue(1'b1, 3'd2, a, x.rd, v, rd, e, st);
      tests_run++;
      if ({v, e, st} !== 3'b101) begin
        fails++;
        $display("FAIL rand_init[%0d]: valid/err/store got %b%b%b want 101", i, v, e, st);
      end
    end
    for (int c = 0; c < int'(ncyc) + 3; c++) begin
      @(negedge clk);
      t_valid  = (c < int'(ncyc)) && ($urandom_range(0, 3) != 0);
      t_we     = 1'($urandom_range(0, 1));
      t_f3     = 3'($urandom_range(0, 7));
      t_wdata  = $urandom;
      t_addr   = ($urandom_range(0, 9) == 0) ? (32'h0010_0000 + $urandom_range(0, 255))
                                             : (32'h200 + $urandom_range(0, 255));
      t_rready = (c >= int'(ncyc)) || ($urandom_range(0, 3) != 0);
      #1;
      tests_run++;
      if ({o_resp_valid, o_req_ready} !== {q.size() != 0, (q.size() == 0) || t_rready}) begin
        fails++;
        $display("FAIL rand_hs[%0d]: valid/ready got %b%b want %b%b", c, o_resp_valid, o_req_ready,
                 q.size() != 0, (q.size() == 0) || t_rready);
      end
      if (q.size() != 0 && t_rready) begin
        x = q.pop_front();
        tests_run++;
        if ({o_resp_err, o_resp_store, o_resp_rdata} !== {x.err, x.st, x.rd}) begin
          fails++;
          $display("FAIL rand_resp[%0d]: err/store/rdata got %b%b %h want %b%b %h",
                   c, o_resp_err, o_resp_store, o_resp_rdata, x.err, x.st, x.rd);
        end
      end
      if (t_valid && o_req_ready === 1'b1) begin
        model_access(t_we, t_f3, t_addr, t_wdata, x.rd, merr);
        x.err = merr;
        x.st  = t_we;
        q.push_back(x);
      end
    end
    t_valid = 1'b0;
    tests_run++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL rand_drain: %0d responses outstanding want 0", q.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sel = 1'b0; t_valid = 1'b0; t_we = 1'b0; t_f3 = 3'd0; t_addr = 32'd0; t_wdata = 32'd0; t_rready = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_reset_mid();
    test_range();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
